// File: rtl/segment_loop_stepper.sv
// Control stage for the seven-segment loop animation: prescaled position stepper
// with a debounced run/pause button, direction select and four speed levels.
module segment_loop_stepper #(
    parameter int DIV_BASE   = 25_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int NPOS       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [2:0] position,
    output logic       step,
    output logic       running
);

    localparam int CNT_W = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
    localparam int LIM_W = CNT_W + 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [2:0]       LAST_POS = 3'(NPOS - 1);
    localparam logic [LIM_W-1:0] BASE_LIM = LIM_W'(DIV_BASE);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_prev;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_position;
    logic             r_step;
    logic             r_running;

    logic [LIM_W-1:0] w_limit;
    logic             w_terminal;
    logic             w_deb_rise;
    logic [2:0]       w_next_pos;

    // limit is one wider than the count so DIV_BASE itself is representable
    assign w_limit    = BASE_LIM >> speed;
    assign w_terminal = ({1'b0, r_count} >= (w_limit - LIM_W'(1)));
    assign w_deb_rise = r_deb & ~r_deb_prev;

    // Wrap-around neighbour of the current position in the selected direction
    always_comb begin
        w_next_pos = r_position;
        if (dir) begin
            if (r_position == 3'd0) begin
                w_next_pos = LAST_POS;
            end else begin
                w_next_pos = r_position - 3'd1;
            end
        end else begin
            if (r_position == LAST_POS) begin
                w_next_pos = 3'd0;
            end else begin
                w_next_pos = r_position + 3'd1;
            end
        end
    end

    // Button synchronizer and debouncer: accept a level once it has differed long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_deb      <= 1'b0;
            r_deb_prev <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_sync1    <= btn_run;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            if (r_sync2 == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb     <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Run/pause toggles one edge after each debounced press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_running <= 1'b1;
        end else if (w_deb_rise) begin
            r_running <= ~r_running;
        end else begin
            r_running <= r_running;
        end
    end

    // Prescaler and position; uses the pre-edge running value so a pause lands after a terminal step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_step     <= 1'b0;
            r_position <= 3'd0;
        end else if (r_running) begin
            if (w_terminal) begin
                r_count    <= '0;
                r_step     <= 1'b1;
                r_position <= w_next_pos;
            end else begin
                r_count    <= r_count + CNT_W'(1);
                r_step     <= 1'b0;
                r_position <= r_position;
            end
        end else begin
            r_count    <= r_count;
            r_step     <= 1'b0;
            r_position <= r_position;
        end
    end

    assign position = r_position;
    assign step     = r_step;
    assign running  = r_running;

endmodule

// File: tb/tb_segment_loop_stepper.sv
// Self-checking bench for segment_loop_stepper: fixed vector table, directed corner
// sequences and randomized stimulus compared against a behavioural model.
module tb_segment_loop_stepper;

    localparam int DIV_BASE = 8;
    localparam int DEB      = 4;
    localparam int NPOS     = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       dir;
    logic [1:0] speed;
    logic [2:0] position;
    logic       step;
    logic       running;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // behavioural model state
    int m_pos;
    int m_cnt;
    bit m_step;
    bit m_run;
    bit m_deb;
    bit m_pend;
    bit pipe[$];
    bit win[$];

    typedef struct {
        bit       rst;
        bit       btn;
        bit       dir;
        bit [1:0] speed;
        int       pos;
        int       stp;
        int       run;
    } vec_t;

    vec_t vecs[15];

    segment_loop_stepper #(
        .DIV_BASE  (DIV_BASE),
        .DEB_CYCLES(DEB),
        .NPOS      (NPOS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn),
        .dir     (dir),
        .speed   (speed),
        .position(position),
        .step    (step),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // One clock edge of the specified behaviour, from the pre-edge state and inputs
    task automatic model_edge(input bit r, input bit b, input bit d, input int sp);
        int lim;
        bit cur;
        bit acc;
        bit old_run;
        if (r) begin
            m_pos  = 0;
            m_cnt  = 0;
            m_step = 0;
            m_run  = 1;
            m_deb  = 0;
            m_pend = 0;
            pipe   = {1'b0, 1'b0};
            win    = {};
        end else begin
            old_run = m_run;
            if (m_pend) m_run = !m_run;
            lim = DIV_BASE >> sp;
            if (old_run && m_cnt >= lim - 1) begin
                m_cnt  = 0;
                m_step = 1;
                m_pos  = d ? (m_pos + NPOS - 1) % NPOS : (m_pos + 1) % NPOS;
            end else if (old_run) begin
                m_cnt++;
                m_step = 0;
            end else begin
                m_step = 0;
            end
            // button seen two edges late; accepted after DEB consecutive differing samples
            cur = pipe.pop_front();
            pipe.push_back(b);
            win.push_back(cur);
            if (win.size() > DEB) void'(win.pop_front());
            acc = (win.size() == DEB);
            foreach (win[i]) if (win[i] == m_deb) acc = 0;
            m_pend = acc && !m_deb;
            if (acc) m_deb = !m_deb;
        end
    endtask

    task automatic cycle(input bit r, input bit b, input bit d, input bit [1:0] sp);
        rst   = r;
        btn   = b;
        dir   = d;
        speed = sp;
        @(posedge clk);
        model_edge(r, b, d, int'(sp));
        #1;
        cyc++;
        check("position", int'(position), m_pos);
        check("step", int'(step), int'(m_step));
        check("running", int'(running), int'(m_run));
    endtask

    initial begin
        int n;
        int hold_pos;
        bit rb;
        bit rd;
        bit [1:0] rs;
        int bhold;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1, 1, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd3, 2, 1, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3, 1, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd3, 4, 1, 1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 5, 1, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd3, 0, 1, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1, 1, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd3, 0, 1, 1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd3, 5, 1, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 4, 1, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd2, 4, 0, 1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd2, 3, 1, 1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd2, 3, 0, 1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd2, 4, 1, 1};

        rst = 1'b1; btn = 1'b0; dir = 1'b0; speed = 2'd0;

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].rst, vecs[i].btn, vecs[i].dir, vecs[i].speed);
            check("vec_pos", int'(position), vecs[i].pos);
            check("vec_step", int'(step), vecs[i].stp);
            check("vec_run", int'(running), vecs[i].run);
        end

        // first step after reset, then a full forward lap
        cycle(1'b1, 1'b0, 1'b0, 2'd0);
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b0, 2'd0); n++; end while (!step && n < 20);
        check("first_step_latency", n, 8);
        check("first_step_pos", int'(position), 1);
        repeat (40) cycle(1'b0, 1'b0, 1'b0, 2'd0);

        // reverse from position 0 wraps to NPOS-1 one full period later
        n = 0;
        while (!(step && position == 3'd0) && n < 100) begin cycle(1'b0, 1'b0, 1'b0, 2'd0); n++; end
        check("reach_pos0", int'(position), 0);
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b1, 2'd0); n++; end while (!step && n < 20);
        check("reverse_interval", n, 8);
        check("reverse_wrap", int'(position), 5);
        repeat (16) cycle(1'b0, 1'b0, 1'b1, 2'd0);

        // fastest speed steps every cycle
        cycle(1'b0, 1'b0, 1'b0, 2'd3);
        check("speed3_step_a", int'(step), 1);
        cycle(1'b0, 1'b0, 1'b0, 2'd3);
        check("speed3_step_b", int'(step), 1);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 2'd2);

        // short glitches are rejected
        repeat (3) begin
            repeat (2) cycle(1'b0, 1'b1, 1'b0, 2'd0);
            repeat (2) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("glitch_running", int'(running), 1);

        // clean press pauses after sync + debounce + toggle latency
        n = 0;
        do begin cycle(1'b0, 1'b1, 1'b0, 2'd0); n++; end while (running && n < 20);
        check("press_latency", n, 7);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 2'd0);
        hold_pos = int'(position);
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("paused_pos", int'(position), hold_pos);
        check("paused_run", int'(running), 0);
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 2'd0);
        check("resumed_run", int'(running), 1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 2'd0);

        // speed raised while count already past the new limit
        cycle(1'b1, 1'b0, 1'b0, 2'd0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd2);
        check("speed_change_step", int'(step), 1);
        cycle(1'b0, 1'b0, 1'b0, 2'd2);
        check("speed_change_gap", int'(step), 0);
        cycle(1'b0, 1'b0, 1'b0, 2'd2);
        check("speed_change_next", int'(step), 1);

        // reset mid-run at position 3
        n = 0;
        while (position != 3'd3 && n < 100) begin cycle(1'b0, 1'b0, 1'b0, 2'd0); n++; end
        check("reach_pos3", int'(position), 3);
        cycle(1'b1, 1'b0, 1'b0, 2'd0);
        check("rst_pos", int'(position), 0);
        check("rst_step", int'(step), 0);
        check("rst_run", int'(running), 1);
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b0, 2'd0); n++; end while (!step && n < 20);
        check("rst_step_latency", n, 8);

        // randomized stimulus against the model
        rb = 1'b0; rd = 1'b0; rs = 2'd0; bhold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) rs = 2'($urandom_range(0, 3));
            if (bhold == 0) begin
                rb = !rb;
                bhold = $urandom_range(1, 9);
            end else begin
                bhold--;
            end
            cycle(($urandom_range(0, 299) == 0), rb, rd, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
